// File: rtl/uart_tx_mmio_if.sv
// Data-memory bus seen by the UART transmitter: store strobe, address and
// store data from the core; combinational load data and address hit back.
interface uart_tx_mmio_if;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        hit;

  modport master (output MemWrite, Addr, WriteData, input ReadData, hit);
  modport slave  (input MemWrite, Addr, WriteData, output ReadData, hit);
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: a small byte FIFO filled by stores to
// TXDATA and drained LSB-first onto the tx pin by a baud-timed serializer.
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int          CLK_DIV    = 234,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  uart_tx_mmio_if.slave bus,
  output logic          tx
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_DIV - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  state_t        state_r, state_nxt_s;
  logic [BW-1:0] baud_r, baud_nxt_s;
  logic [2:0]    bit_idx_r, bit_idx_nxt_s;
  logic [7:0]    shift_r, shift_nxt_s;
  logic          tx_r, tx_nxt_s;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          ovf_r, en_r;

  logic          hit_s, wr_s, wr_data_s, wr_status_s, wr_ctrl_s;
  logic          full_s, empty_s, busy_s, push_s, pop_s;
  logic [31:0]   rdata_s;
  logic          unused_s;

  assign hit_s       = (bus.Addr[31:4] == BASE_ADDR[31:4]);
  assign wr_s        = bus.MemWrite && hit_s;
  assign wr_data_s   = wr_s && (bus.Addr[3:2] == 2'd0);
  assign wr_status_s = wr_s && (bus.Addr[3:2] == 2'd1);
  assign wr_ctrl_s   = wr_s && (bus.Addr[3:2] == 2'd2);

  // Full/empty come from the count registered at the start of the cycle, so a
  // push into a full FIFO is dropped even when a pop happens alongside it.
  assign full_s  = (count_r == DEPTH_C);
  assign empty_s = (count_r == {CW{1'b0}});
  assign busy_s  = (state_r != ST_IDLE);
  assign pop_s   = (state_r == ST_IDLE) && en_r && !empty_s;
  assign push_s  = wr_data_s && !full_s;

  assign bus.hit      = hit_s;
  assign bus.ReadData = rdata_s;
  assign tx           = tx_r;
  assign unused_s     = ^{bus.WriteData[31:8], bus.Addr[1:0]};

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (push_s) mem[wr_ptr_r] <= bus.WriteData[7:0];
  end

  // Sticky overflow flag (write-1-to-clear) and transmit enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_r <= 1'b0;
      en_r  <= 1'b1;
    end else begin
      if (wr_data_s && full_s)                  ovf_r <= 1'b1;
      else if (wr_status_s && bus.WriteData[3]) ovf_r <= 1'b0;
      if (wr_ctrl_s) en_r <= bus.WriteData[0];
    end
  end

  // Serializer state register; tx leaves from a flop so it never glitches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      baud_r    <= {BW{1'b0}};
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      tx_r      <= 1'b1;
    end else begin
      state_r   <= state_nxt_s;
      baud_r    <= baud_nxt_s;
      bit_idx_r <= bit_idx_nxt_s;
      shift_r   <= shift_nxt_s;
      tx_r      <= tx_nxt_s;
    end
  end

  // Serializer next state: each phase holds tx for CLK_DIV cycles, data shifts out LSB first.
  always_comb begin
    state_nxt_s   = state_r;
    baud_nxt_s    = baud_r;
    bit_idx_nxt_s = bit_idx_r;
    shift_nxt_s   = shift_r;
    tx_nxt_s      = tx_r;
    case (state_r)
      ST_IDLE: begin
        if (pop_s) begin
          state_nxt_s = ST_START;
          baud_nxt_s  = BAUD_MAX;
          shift_nxt_s = mem[rd_ptr_r];
          tx_nxt_s    = 1'b0;
        end else begin
          tx_nxt_s    = 1'b1;
        end
      end
      ST_START: begin
        if (baud_r == {BW{1'b0}}) begin
          state_nxt_s   = ST_DATA;
          baud_nxt_s    = BAUD_MAX;
          bit_idx_nxt_s = 3'd0;
          tx_nxt_s      = shift_r[0];
        end else begin
          baud_nxt_s    = baud_r - BW'(1);
        end
      end
      ST_DATA: begin
        if (baud_r != {BW{1'b0}}) begin
          baud_nxt_s = baud_r - BW'(1);
        end else if (bit_idx_r == 3'd7) begin
          state_nxt_s = ST_STOP;
          baud_nxt_s  = BAUD_MAX;
          tx_nxt_s    = 1'b1;
        end else begin
          baud_nxt_s    = BAUD_MAX;
          bit_idx_nxt_s = bit_idx_r + 3'd1;
          shift_nxt_s   = {1'b0, shift_r[7:1]};
          tx_nxt_s      = shift_r[1];
        end
      end
      ST_STOP: begin
        if (baud_r == {BW{1'b0}}) begin
          state_nxt_s = ST_IDLE;
          tx_nxt_s    = 1'b1;
        end else begin
          baud_nxt_s  = baud_r - BW'(1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        tx_nxt_s    = 1'b1;
      end
    endcase
  end

  // Load data: purely combinational from the address and registered state.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (hit_s) begin
      case (bus.Addr[3:2])
        2'd1:    rdata_s = {16'h0000, 8'(count_r), 4'h0, ovf_r, busy_s, empty_s, full_s};
        2'd2:    rdata_s = {31'h0000_0000, en_r};
        default: rdata_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: a queue-based reference model checked every cycle,
// an independent line receiver, and literal expectations for key scenarios.
module tb_uart_tx_mmio;
  localparam int          N      = 4;
  localparam int          D      = 8;
  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam logic [27:0] BASE_HI = 28'h000_0100;
  localparam int          PERIOD = 10 * N + 1;

  logic clk, reset_n, tx;
  uart_tx_mmio_if bus();

  uart_tx_mmio #(.BASE_ADDR(BASE), .CLK_DIV(N), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .tx(tx)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // reference model state
  logic [7:0] m_q[$];
  bit         m_ovf, m_en, m_active;
  int         m_age;
  logic [7:0] m_byte;

  // receiver results
  logic [7:0] rx_q[$];
  int         start_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_q.delete();
    m_ovf = 1'b0;
    m_en = 1'b1;
    m_active = 1'b0;
    m_age = 0;
    m_byte = 8'h00;
  endfunction

  // One clock of the spec rules: pop decision and full test use start-of-cycle occupancy.
  function automatic void m_update();
    int cnt = m_q.size();
    bit hit_m = (bus.Addr[31:4] == BASE_HI);
    bit pop = !m_active && m_en && (cnt != 0);
    if (m_active) begin
      if (m_age == 10 * N - 1) m_active = 1'b0;
      else m_age++;
    end
    if (pop) begin
      m_byte = m_q.pop_front();
      m_active = 1'b1;
      m_age = 0;
    end
    if (bus.MemWrite && hit_m) begin
      case (bus.Addr[3:2])
        2'd0: if (cnt == D) m_ovf = 1'b1; else m_q.push_back(bus.WriteData[7:0]);
        2'd1: if (bus.WriteData[3]) m_ovf = 1'b0;
        2'd2: m_en = bus.WriteData[0];
        default: ;
      endcase
    end
  endfunction

  function automatic logic exp_tx();
    if (!m_active) return 1'b1;
    if (m_age < N) return 1'b0;
    if (m_age < 9 * N) return m_byte[(m_age - N) / N];
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_rdata();
    logic [31:0] s;
    logic [7:0]  c;
    s = 32'h0;
    if (bus.Addr[31:4] != BASE_HI) return 32'h0;
    c = 8'(m_q.size());
    case (bus.Addr[3:2])
      2'd1: begin
        s[0] = (m_q.size() == D);
        s[1] = (m_q.size() == 0);
        s[2] = m_active;
        s[3] = m_ovf;
        s[15:8] = c;
      end
      2'd2: s[0] = m_en;
      default: s = 32'h0;
    endcase
    return s;
  endfunction

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) m_reset();
      else m_update();
    end
  end

  // every-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    check("tx_cycle", 32'(tx), 32'(exp_tx()));
    check("hit_cycle", 32'(bus.hit), 32'((bus.Addr[31:4] == BASE_HI)));
    check("rdata_cycle", bus.ReadData, exp_rdata());
  end

  // independent 8N1 receiver sampling mid-bit
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && tx === 1'b0) begin
        start_q.push_back(cyc);
        repeat (N / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (N) @(negedge clk);
          b[i] = tx;
        end
        repeat (N) @(negedge clk);
        check("rx_stop", 32'(tx), 32'd1);
        rx_q.push_back(b);
        repeat (N / 2 - 1) @(negedge clk);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    step();
    bus.MemWrite = 1'b1;
    bus.Addr = a;
    bus.WriteData = d;
    step();
    bus.MemWrite = 1'b0;
    bus.Addr = BASE + 32'h4;
    #1;
  endtask

  task automatic expect_rx(input string name, input logic [7:0] exp[$]);
    logic [7:0] got;
    check({name, "_count"}, 32'(rx_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      check(name, 32'(got), 32'(exp[i]));
    end
  endtask

  initial begin
    logic [9:0] frame;
    logic [7:0] exp_b[$];
    logic [7:0] src[20];
    int idx;

    reset_n = 1'b0;
    bus.MemWrite = 1'b0;
    bus.Addr = BASE + 32'h4;
    bus.WriteData = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_status", bus.ReadData, 32'h0000_0002);
    bus.Addr = BASE + 32'h8;
    #1 check("reset_ctrl", bus.ReadData, 32'h0000_0001);
    bus.Addr = BASE + 32'h4;
    step();

    // single byte 0x55
    bus_write(BASE, 32'h0000_0055);
    check("t1_pop_cycle_tx", 32'(tx), 32'd1);
    check("t1_pop_cycle_status", bus.ReadData, 32'h0000_0100);
    frame = {1'b1, 8'h55, 1'b0};
    for (int k = 0; k < 10 * N; k++) begin
      step();
      check("t1_tx", 32'(tx), 32'(frame[k / N]));
      check("t1_busy", 32'(bus.ReadData[2]), 32'd1);
    end
    step();
    check("t1_idle_status", bus.ReadData, 32'h0000_0002);
    check("t1_idle_tx", 32'(tx), 32'd1);
    repeat (4) step();
    exp_b = '{8'h55};
    expect_rx("t1_rx", exp_b);

    // overflow with enable off
    rx_q.delete();
    bus_write(BASE + 32'h8, 32'h0);
    for (int i = 0; i < 9; i++) bus_write(BASE, 32'(i));
    check("t2_status_full_ovf", bus.ReadData, 32'h0000_0809);
    bus_write(BASE + 32'h4, 32'h0000_0008);
    check("t2_status_ovf_clr", bus.ReadData, 32'h0000_0801);
    bus_write(BASE + 32'h8, 32'h1);
    repeat (8 * PERIOD + 8) step();
    exp_b = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    expect_rx("t2_rx", exp_b);
    check("t2_status_end", bus.ReadData, 32'h0000_0002);

    // back-to-back frames
    rx_q.delete();
    start_q.delete();
    bus_write(BASE, 32'h0000_00A5);
    bus_write(BASE, 32'h0000_003C);
    repeat (2 * PERIOD + 8) step();
    exp_b = '{8'hA5, 8'h3C};
    expect_rx("t3_rx", exp_b);
    check("t3_starts", 32'(start_q.size()), 32'd2);
    if (start_q.size() == 2) check("t3_period", 32'(start_q[1] - start_q[0]), 32'(PERIOD));

    // streaming 20 random bytes through the 8-deep FIFO
    rx_q.delete();
    for (int i = 0; i < 20; i++) src[i] = 8'($urandom_range(0, 255));
    idx = 0;
    for (int g = 0; g < 3000 && idx < 20; g++) begin
      if (m_q.size() < D && (idx < 2 || $urandom_range(0, 3) != 0)) begin
        bus.MemWrite = 1'b1;
        bus.Addr = BASE;
        bus.WriteData = 32'(src[idx]);
        idx++;
        #1;
      end else begin
        bus.MemWrite = 1'b0;
        bus.Addr = BASE + 32'h4;
        #1 check("t4_count_le_depth", 32'(bus.ReadData[15:8] <= 8'd8), 32'd1);
      end
      step();
    end
    bus.MemWrite = 1'b0;
    bus.Addr = BASE + 32'h4;
    check("t4_all_written", 32'(idx), 32'd20);
    repeat (10 * PERIOD) step();
    exp_b.delete();
    for (int i = 0; i < 20; i++) exp_b.push_back(src[i]);
    expect_rx("t4_rx", exp_b);

    // reset during DATA bit 3
    bus_write(BASE, 32'h0);
    bus_write(BASE, 32'h0);
    bus_write(BASE + 32'h8, 32'h0);
    repeat (4 * N - 3) step();
    check("t5_pre_reset_tx", 32'(tx), 32'd0);
    reset_n = 1'b0;
    #1 check("t5_reset_tx", 32'(tx), 32'd1);
    step();
    step();
    reset_n = 1'b1;
    #1 check("t5_status", bus.ReadData, 32'h0000_0002);
    bus.Addr = BASE + 32'h8;
    #1 check("t5_ctrl", bus.ReadData, 32'h0000_0001);
    bus.Addr = BASE + 32'h4;
    repeat (2 * PERIOD) step();
    rx_q.delete();
    start_q.delete();

    // address decode and write qualification
    bus.Addr = BASE + 32'h20;
    #1;
    check("t6_miss_hit", 32'(bus.hit), 32'd0);
    check("t6_miss_rdata", bus.ReadData, 32'h0);
    bus_write(BASE + 32'h20, 32'h0000_0011);
    bus_write(BASE + 32'hC, 32'hFFFF_FFFF);
    check("t6_status", bus.ReadData, 32'h0000_0002);
    bus.Addr = BASE + 32'h8;
    #1 check("t6_ctrl", bus.ReadData, 32'h0000_0001);
    bus.Addr = BASE + 32'hC;
    #1 check("t6_rsvd_hit", 32'(bus.hit), 32'd1);
    check("t6_rsvd_rdata", bus.ReadData, 32'h0);
    bus.Addr = BASE;
    bus.WriteData = 32'h0000_0077;
    #1 check("t6_txdata_rdata", bus.ReadData, 32'h0);
    step();
    bus.Addr = BASE + 32'h4;
    #1 check("t6_no_push", bus.ReadData, 32'h0000_0002);
    repeat (3 * N) step();
    check("t6_tx_idle", 32'(tx), 32'd1);
    check("t6_no_frames", 32'(start_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
